// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The loader FSM and its byte-to-word assembler both import this package.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the stream handshake is open and the idle timer runs.
    function automatic logic accepts_bytes(input state_e s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Packs accepted stream bytes into a little-endian word; word_ready pulses
// combinationally alongside the strobe of the final byte of each word.
module imem_boot_loader_byte_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          byte_stb,
    input  logic [7:0]                    byte_in,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_ready
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [8*BYTES_PER_WORD-1:0]   word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr) begin
            idx_d = '0;
        end else if (byte_stb) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d                        = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word       = word_q;
    assign word_ready = byte_stb && !clr && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory and holds
// the core in reset until the whole image has landed.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int CNT_W  = 8 * HDR_BYTES;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_WIDTH:0] words_q, words_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                byte_ready_q, imem_we_q, busy_q, done_q, error_q, core_reset_q;
    logic                byte_ready_d, imem_we_d, busy_d, done_d, error_d, core_reset_d;
    logic                hs, asm_clr, asm_stb, word_ready;
    logic [31:0]         asm_word;
    logic [CNT_W-1:0]    hdr_count;

    assign hs        = byte_valid && byte_ready_q;
    assign asm_stb   = hs && (state_q == ST_DATA);
    assign hdr_count = {byte_data, count_q[7:0]};

    imem_boot_loader_byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (asm_clr),
        .byte_stb   (asm_stb),
        .byte_in    (byte_data),
        .word       (asm_word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        idle_d  = '0;
        asm_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_LO;
                    count_d = '0;
                    words_d = '0;
                    asm_clr = 1'b1;
                end
            end
            ST_HDR_LO: begin
                if (hs) begin
                    count_d[7:0] = byte_data;
                    state_d      = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (hs) begin
                    count_d = hdr_count;
                    if (hdr_count == '0 || 32'(hdr_count) > 32'(MAX_WORDS))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                words_d = words_q + 1'b1;
                asm_clr = 1'b1;
                state_d = (32'(words_d) == 32'(count_q)) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte always beats timer expiry on the same cycle.
        if (accepts_bytes(state_q) && !hs) begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_W'(TIMEOUT_CYCLES)) state_d = ST_ERR;
        end
    end

    // Status outputs are flopped from the next state so they line up with it.
    assign byte_ready_d = accepts_bytes(state_d);
    assign imem_we_d    = (state_d == ST_WRITE);
    assign busy_d       = accepts_bytes(state_d) || (state_d == ST_WRITE);
    assign done_d       = (state_d == ST_DONE);
    assign error_d      = (state_d == ST_ERR);
    assign core_reset_d = (state_d != ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            words_q      <= '0;
            idle_q       <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            words_q      <= words_d;
            idle_q       <= idle_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = words_q[ADDR_WIDTH-1:0];
    assign imem_wdata   = asm_word;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized image
// loads compared against a byte-list reference model of the expected writes.
module tb_imem_boot_loader;
    localparam int AW = 8;
    localparam int MW = 256;
    localparam int TO = 300;

    logic          clk = 1'b0;
    logic          reset, start, byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready, imem_we, core_reset, busy, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_loaded;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_q[$];

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back('{addr: int'(imem_addr), data: imem_wdata});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: data word i of an image is bytes 2+4i..2+4i+3, little-endian.
    function automatic logic [31:0] model_word(input logic [7:0] s[$], input int i);
        int b;
        b = 2 + 4 * i;
        return {s[b+3], s[b+2], s[b+1], s[b]};
    endfunction

    function automatic void make_image(input int n, output logic [7:0] s[$]);
        s = {};
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(0, 255)));
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, output bit ok);
        byte_valid = 1'b0;
        repeat (gap) begin
            start = noise && ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        ok         = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = byte_ready;
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap, input bit noise,
                               output int nacc);
        bit ok;
        nacc = 0;
        foreach (s[i]) begin
            send_byte(s[i], $urandom_range(0, max_gap), noise, ok);
            if (!ok) break;
            nacc++;
        end
    endtask

    task automatic wait_end(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = done || error;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({byte_ready, imem_we, core_reset, busy, done, error} !== 6'b001000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 001000",
                     {byte_ready, imem_we, core_reset, busy, done, error});
        end
        vectors++;
        if (imem_addr !== '0 || imem_wdata !== '0 || words_loaded !== '0) begin
            miscompares++;
            $display("FAIL reset_values: addr=%h wdata=%h words=%0d want 0", imem_addr, imem_wdata, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        int nacc;
        bit seen;
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        wr_q.delete();
        do_start();
        vectors++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: busy=%b ready=%b want 1 1", busy, byte_ready);
        end
        send_stream(s, 0, 1'b0, nacc);
        wait_end(seen);
        vectors++;
        if (wr_q.size() != 2) begin
            miscompares++;
            $display("FAIL basic_nwrites: got %0d want 2", wr_q.size());
        end else begin
            vectors++;
            if (wr_q[0].addr != 0 || wr_q[0].data !== 32'h00100513 ||
                wr_q[1].addr != 1 || wr_q[1].data !== 32'h00200593) begin
                miscompares++;
                $display("FAIL basic_words: got %0d:%h %0d:%h want 0:00100513 1:00200593",
                         wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data);
            end
        end
        vectors++;
        if (done !== 1'b1 || core_reset !== 1'b0 || busy !== 1'b0 || words_loaded !== 9'd2) begin
            miscompares++;
            $display("FAIL basic_done: done=%b core_reset=%b busy=%b words=%0d want 1 0 0 2",
                     done, core_reset, busy, words_loaded);
        end
    endtask

    task automatic test_zero_header();
        logic [7:0] s[$];
        int nacc;
        bit seen;
        wr_q.delete();
        do_start();
        vectors++;
        if (core_reset !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_core_reset: core_reset=%b done=%b want 1 0", core_reset, done);
        end
        s = '{8'h00, 8'h00};
        send_stream(s, 0, 1'b0, nacc);
        repeat (3) @(negedge clk);
        vectors++;
        if (error !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0 || wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_hdr: error=%b core_reset=%b busy=%b writes=%0d want 1 1 0 0",
                     error, core_reset, busy, wr_q.size());
        end
        make_image(1, s);
        do_start();
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: error=%b want 0", error);
        end
        send_stream(s, 0, 1'b0, nacc);
        wait_end(seen);
        vectors++;
        if (done !== 1'b1 || wr_q.size() != 1 || wr_q[0].addr != 0 || wr_q[0].data !== model_word(s, 0)) begin
            miscompares++;
            $display("FAIL zero_hdr_recover: done=%b writes=%0d data=%h want 1 1 %h",
                     done, wr_q.size(), (wr_q.size() > 0) ? wr_q[0].data : 32'hx, model_word(s, 0));
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        int nacc;
        wr_q.delete();
        do_start();
        s = '{8'h01, 8'h01};
        send_stream(s, 0, 1'b0, nacc);
        vectors++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize_err: error=%b ready=%b busy=%b want 1 0 0", error, byte_ready, busy);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL oversize_writes: got %0d want 0", wr_q.size());
        end
    endtask

    task automatic test_max_count();
        logic [7:0] s[$];
        int nacc, bad;
        bit seen;
        wr_q.delete();
        make_image(MW, s);
        do_start();
        send_stream(s, 0, 1'b0, nacc);
        wait_end(seen);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i].addr != i || wr_q[i].data !== model_word(s, i)) bad++;
        vectors++;
        if (wr_q.size() != MW || bad != 0 || done !== 1'b1 || words_loaded !== 9'(MW)) begin
            miscompares++;
            $display("FAIL max_count: writes=%0d bad=%0d done=%b words=%0d want %0d 0 1 %0d",
                     wr_q.size(), bad, done, words_loaded, MW, MW);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        int nacc;
        wr_q.delete();
        make_image(3, s);
        s = s[0:6];
        do_start();
        send_stream(s, 0, 1'b0, nacc);
        repeat (TO - 1) @(negedge clk);
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: error=%b busy=%b want 0 1", error, busy);
        end
        @(negedge clk);
        vectors++;
        if (error !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_expire: error=%b core_reset=%b busy=%b want 1 1 0", error, core_reset, busy);
        end
        vectors++;
        if (wr_q.size() != 1 || words_loaded !== 9'd1 || wr_q[0].data !== model_word(s, 0)) begin
            miscompares++;
            $display("FAIL timeout_writes: writes=%0d words=%0d want 1 1", wr_q.size(), words_loaded);
        end
    endtask

    task automatic test_random_gaps();
        logic [7:0] s[$];
        int nacc, n, bad;
        bit seen;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 6);
            make_image(n, s);
            wr_q.delete();
            do_start();
            send_stream(s, 3, 1'b1, nacc);
            wait_end(seen);
            bad = 0;
            foreach (wr_q[i]) if (wr_q[i].addr != i || wr_q[i].data !== model_word(s, i)) bad++;
            vectors++;
            if (wr_q.size() != n || bad != 0 || done !== 1'b1 || words_loaded !== 9'(n)) begin
                miscompares++;
                $display("FAIL random_load%0d: writes=%0d bad=%0d done=%b words=%0d want %0d 0 1 %0d",
                         it, wr_q.size(), bad, done, words_loaded, n, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        int nacc;
        bit seen;
        wr_q.delete();
        make_image(4, s);
        s = s[0:7];
        do_start();
        send_stream(s, 0, 1'b0, nacc);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || core_reset !== 1'b1 || byte_ready !== 1'b0 || words_loaded !== '0) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b core_reset=%b ready=%b words=%0d want 0 1 0 0",
                     busy, core_reset, byte_ready, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr_q.delete();
        make_image(2, s);
        do_start();
        send_stream(s, 1, 1'b0, nacc);
        wait_end(seen);
        vectors++;
        if (wr_q.size() != 2 || wr_q[0].addr != 0 || wr_q[0].data !== model_word(s, 0) ||
            wr_q[1].addr != 1 || wr_q[1].data !== model_word(s, 1) || done !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_reload: writes=%0d done=%b want 2 1", wr_q.size(), done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_header();
        test_oversize();
        test_max_count();
        test_timeout();
        test_random_gaps();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Program loader upstream of the single-cycle core's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words sequentially from word address 0 through a dedicated write port on the instruction memory.
- Holds the core in reset until a complete image has been written.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory
MAX_WORDS, 256, largest accepted image size in words (must be <= 2**ADDR_WIDTH)
TIMEOUT_CYCLES, 65535, idle cycles allowed between accepted bytes before abort

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  word to write
core_reset  output  1  reset to the processor core
busy  output  1  load in progress
done  output  1  last load completed successfully
error  output  1  last load aborted
words_loaded  output  ADDR_WIDTH+1  words written in current/last load

Behaviour:
- A byte transfers on a rising edge when byte_valid && byte_ready.
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
- Reset (async): state=IDLE, all counters and the word assembler cleared. Outputs: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, error=0, words_loaded=0.
- core_reset=1 in every state except DONE.
- IDLE: start -> HDR_LO; clears words_loaded, done and error.
- HDR_LO: byte_ready=1; an accepted byte becomes count[7:0]; -> HDR_HI.
- HDR_HI: byte_ready=1; an accepted byte becomes count[15:8].
  - count==0 or count>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: byte_ready=1. Accepted byte k (k=0..3) goes to word bits [8k+7:8k], little-endian. The 4th accepted byte -> WRITE.
- WRITE: lasts exactly one cycle.
  - Outputs: imem_we=1, imem_addr=words_loaded[ADDR_WIDTH-1:0], imem_wdata=assembled word, byte_ready=0.
  - Next edge: words_loaded++.
  - If the new value == count -> DONE; else -> DATA with the byte index cleared.
- Outputs are registered. Latency is 1 cycle from the 4th byte handshake to imem_we.
- busy=1 in HDR_LO, HDR_HI, DATA and WRITE.
- DONE: done=1, core_reset=0. start -> HDR_LO (done cleared, words_loaded=0, core_reset reasserted the same edge).
- ERR: error=1, core_reset=1. start -> HDR_LO; error clears.
- start while busy is ignored.
- Timeout:
  - The idle counter runs in HDR_LO, HDR_HI and DATA.
  - It clears on every accepted byte and on entry to those states.
  - Reaching TIMEOUT_CYCLES -> ERR. Words already written remain in memory.
  - A handshake on the same cycle as timeout expiry wins: the byte is accepted and the counter clears.
- byte_valid while byte_ready=0 is not consumed; the producer holds the byte.
- Reset mid-load returns to IDLE immediately. Partially written memory is not cleaned.
- A count of exactly MAX_WORDS is legal. imem_addr never wraps because count is bounded.

Decomposition:
- Shared package holds the state enum (7 encodings, 3 bits), the header byte count (2), and bytes-per-word (4).
- One natural sub-module: byte_word_assembler. It takes byte/strobe in and produces a 32-bit word plus a word_ready pulse, with a clear input driven by the FSM.

Test Plan:
1. Reset -> all outputs at reset values. Pulse start; stream 02 00 13 05 10 00 93 05 20 00 -> two writes: addr0=0x00100513, addr1=0x00200593. Then done=1, core_reset=0, words_loaded=2.
2. Header 00 00 -> error=1, core_reset=1, no imem_we. A following start with a valid 1-word image -> done=1.
3. Header 01 01 (257 > MAX_WORDS) -> ERR after the 2nd byte; no writes.
4. Valid header for 3 words, then stall for TIMEOUT_CYCLES after 5 data bytes -> error=1, exactly 1 write observed, words_loaded=1.
5. Random byte_valid gaps and start pulses while busy -> identical written words to the gap-free run, start ignored, imem_we high exactly once per 4 bytes.
6. Assert reset during DATA after 6 data bytes -> IDLE immediately (asynchronous), core_reset=1, busy=0. A subsequent full load succeeds from addr 0.
